// File: rtl/baud_gen.sv
// baud_gen: divides clk by a loadable 16-bit divisor D to produce rx_en,
// and by OVERSAMPLE*D to produce tx_en. All outputs are registered.
`timescale 1ns/1ps
`default_nettype none

module baud_gen #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div_buf,
  input  logic        buf_rdy,
  output logic        rx_en,
  output logic        tx_en,
  output logic        running
);

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       div_reg, div_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic [OS_W-1:0]   os_cnt, os_nxt;
  logic              rx_nxt, tx_nxt, run_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_reg <= 16'd0;
      cnt     <= 16'd0;
      os_cnt  <= '0;
      rx_en   <= 1'b0;
      tx_en   <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_reg <= div_nxt;
      cnt     <= cnt_nxt;
      os_cnt  <= os_nxt;
      rx_en   <= rx_nxt;
      tx_en   <= tx_nxt;
      running <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_reg;
    cnt_nxt   = cnt;
    os_nxt    = os_cnt;
    rx_nxt    = 1'b0;
    tx_nxt    = 1'b0;
    run_nxt   = running;

    if (buf_rdy) begin
      // A load wins over any tick due this cycle and restarts the phase.
      div_nxt = div_buf;
      os_nxt  = '0;
      if (div_buf == 16'd0) begin
        cnt_nxt   = 16'd0;
        state_nxt = IDLE;
        run_nxt   = 1'b0;
      end else begin
        cnt_nxt   = div_buf - 16'd1;
        state_nxt = RUN;
        run_nxt   = 1'b1;
      end
    end else if (state == RUN) begin
      if (cnt == 16'd0) begin
        cnt_nxt = div_reg - 16'd1;
        rx_nxt  = 1'b1;
        tx_nxt  = (os_cnt == OS_LAST);
        os_nxt  = os_cnt + 1'b1;
      end else begin
        cnt_nxt = cnt - 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_baud_gen.sv
// Directed self-checking bench for baud_gen with OVERSAMPLE=16.
`timescale 1ns/1ps
`default_nettype none

module tb_baud_gen;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] div_buf = 16'd0;
  logic        buf_rdy = 1'b0;
  logic        rx_en, tx_en, running;

  int checks   = 0;
  int failures = 0;
  int rx_cnt, tx_cnt;

  baud_gen #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_buf (div_buf),
    .buf_rdy (buf_rdy),
    .rx_en   (rx_en),
    .tx_en   (tx_en),
    .running (running)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a divisor for one edge, then scramble div_buf (must be ignored).
  task automatic load(input logic [15:0] d, input string tag);
    buf_rdy = 1'b1;
    div_buf = d;
    tick();
    buf_rdy = 1'b0;
    div_buf = ~d;
    check({tag, "_load_rx"},  rx_en,   1'b0);
    check({tag, "_load_tx"},  tx_en,   1'b0);
    check({tag, "_load_run"}, running, (d != 16'd0));
  endtask

  // n cycles after a load of nonzero d: rx on multiples of d, tx on multiples of 16*d.
  task automatic run_check(input int d, input int n, input string tag);
    rx_cnt = 0;
    tx_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      check({tag, "_rx"},  rx_en,   (i % d) == 0);
      check({tag, "_tx"},  tx_en,   (i % (OS * d)) == 0);
      check({tag, "_run"}, running, 1'b1);
      if (rx_en) rx_cnt++;
      if (tx_en) tx_cnt++;
    end
  endtask

  task automatic quiet_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rx"},  rx_en,   1'b0);
      check({tag, "_tx"},  tx_en,   1'b0);
      check({tag, "_run"}, running, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Reset together with a load request: reset must win.
    rst     = 1'b1;
    buf_rdy = 1'b1;
    div_buf = 16'h0005;
    tick();
    tick();
    rst     = 1'b0;
    buf_rdy = 1'b0;
    quiet_check(200, "reset");

    // D=4: 256 rx and 16 tx in 1024 clocks.
    load(16'd4, "d4");
    run_check(4, 1024, "d4");
    check_int("d4_rx_count", rx_cnt, 1024 / 4);
    check_int("d4_tx_count", tx_cnt, 1024 / (OS * 4));

    // D=1: rx continuous, tx every 16 clocks.
    load(16'd1, "d1");
    run_check(1, 64, "d1");
    check_int("d1_rx_count", rx_cnt, 64);
    check_int("d1_tx_count", tx_cnt, 4);

    // D=10 then D=0 on an edge where a tick is due.
    load(16'd10, "d10");
    run_check(10, 19, "d10");
    load(16'd0, "d0");
    quiet_check(100, "d0");

    // D=100 with 7 ticks taken and 50 clocks into the period, then D=3.
    load(16'd100, "d100");
    run_check(100, 750, "d100");
    check_int("d100_rx_count", rx_cnt, 7);
    load(16'd3, "d3");
    run_check(3, 96, "d3");
    check_int("d3_tx_count", tx_cnt, 2);

    // D=6 interrupted by a one-cycle reset, then reloaded.
    load(16'd6, "d6a");
    run_check(6, 9, "d6a");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    quiet_check(30, "d6_rst");
    load(16'd6, "d6b");
    run_check(6, 100, "d6b");
    check_int("d6b_rx_count", rx_cnt, 16);
    check_int("d6b_tx_count", tx_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
